pwm_dac: RTL and testbench
==========================

Name: pwm_dac

Overview:
- Downstream stage of the full-wave waveform generator. Consumes its 8-bit unsigned sample stream.
- Converts each sample into a fixed-period pulse-width-modulated bit for an external RC-filter DAC on the lab board.
- Latches one sample per PWM frame and applies a selectable power-of-two attenuation.
- Emits a frame strobe so upstream logic can advance the generator once per frame.

Parameters:
- WIDTH, 8, sample/duty width; PWM frame length is 2^WIDTH clocks.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  run enable, synchronous
- sample_in  input  WIDTH  unsigned sample from the waveform generator
- amp_sel  input  2  attenuation: latched duty = sample_in >> amp_sel
- pwm_out  output  1  registered PWM bit
- duty_q  output  WIDTH  duty value currently in use
- frame_start  output  1  one-cycle pulse, first cycle of each frame

Behaviour:
- Reset (rst low, asynchronous):
  - cnt = all ones (255)
  - duty_q = 0
  - pwm_out = 0
  - frame_start = 0
  - Release is synchronous to clk. Reset mid-frame aborts the frame immediately.
- Counter:
  - cnt is WIDTH bits, internal.
  - On each edge with en=1: cnt <= cnt+1, wrapping all-ones -> 0.
  - On each edge with en=0: cnt <= all ones; duty_q holds; pwm_out <= 0; frame_start <= 0.
- Latch:
  - On an edge with en=1 and cnt==all ones: duty_q <= sample_in >> amp_sel, logical shift with zero fill.
  - sample_in and amp_sel are ignored at all other edges. Mid-frame changes have no effect until the next frame.
- frame_start:
  - Registered; equals 1 for exactly the cycle in which cnt==0 following a latch, otherwise 0.
  - Asserts once every 2^WIDTH cycles while en stays high.
- pwm_out:
  - Registered, one cycle of latency: pwm_out <= en & (cnt < duty_q), using values present before the edge.
  - Within each frame, pwm_out is high for exactly duty_q consecutive cycles. The first high cycle is the cycle after frame_start.
  - duty_q=0 -> constant 0.
  - duty_q=all ones -> high 255 of 256 cycles. 100% duty is not reachable, by design.
- Enable start-up:
  - Because en=0 parks cnt at all ones, the first enabled edge latches a sample at once.
  - frame_start appears the next cycle. No partial frame is ever produced.
- en deasserted mid-frame: the frame is truncated; pwm_out is 0 from the next cycle on.
- Simultaneous events: rst dominates en. A latch and the wrap to 0 occur on the same edge.
- Width rules: comparison is unsigned and WIDTH bits wide. The shift never overflows.

Test Plan:
- Reset: assert rst=0 mid-frame with en=1 -> same cycle pwm_out=0, duty_q=0, frame_start=0. After release with en=0, cnt stays 255 and outputs stay 0.
- Start-up latch: en 0->1 with sample_in=8'd100, amp_sel=0 -> duty_q=100 after the first edge, frame_start high the next cycle. pwm_out then high for exactly 100 cycles and low for 156; frame_start repeats every 256 cycles.
- Attenuation: sample_in=8'd200 with amp_sel=0,1,2,3 over successive frames -> duty_q=200,100,50,25. Measured high times match each value exactly.
- Extremes: sample_in=0 -> pwm_out never high over 3 frames. sample_in=255, amp_sel=0 -> 255 high and 1 low per frame.
- Mid-frame change: set sample_in=40 at latch, switch to 220 at cnt=10 -> current frame high count stays 40; the next frame is 220.
- Chain with the waveform generator: feed its output, advanced once per frame_start, for 64 frames -> every duty_q equals the reference model's sample; pwm_out high count per frame equals duty_q.

Source files
------------

// File: rtl/pwm_dac_if.sv
// Sample/control bus between the waveform generator side and the PWM DAC stage.
interface pwm_dac_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] sample_in;
  logic [1:0]       amp_sel;
  logic             pwm_out;
  logic [WIDTH-1:0] duty_q;
  logic             frame_start;

  modport master (
    output en, sample_in, amp_sel,
    input  pwm_out, duty_q, frame_start
  );

  modport slave (
    input  en, sample_in, amp_sel,
    output pwm_out, duty_q, frame_start
  );
endinterface

// File: rtl/pwm_dac.sv
// Fixed-period PWM DAC: latches one attenuated sample per 2^WIDTH-clock frame
// and emits a one-cycle frame strobe so the generator advances once per frame.
module pwm_dac #(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  pwm_dac_if.slave  dac_if
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] duty_q,  duty_d;
  logic             pwm_q,   pwm_d;
  logic             frame_q, frame_d;

  // State registers; reset parks the counter so the first enabled edge latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= CNT_MAX;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      frame_q <= frame_d;
    end
  end

  // Latch and wrap share the cnt==max edge; pwm compares against the pre-edge duty.
  always_comb begin
    cnt_d   = CNT_MAX;
    duty_d  = duty_q;
    pwm_d   = 1'b0;
    frame_d = 1'b0;
    if (dac_if.en) begin
      cnt_d   = cnt_q + WIDTH'(1);
      pwm_d   = (cnt_q < duty_q);
      frame_d = (cnt_q == CNT_MAX);
      if (cnt_q == CNT_MAX) begin
        duty_d = dac_if.sample_in >> dac_if.amp_sel;
      end
    end
  end

  assign dac_if.pwm_out     = pwm_q;
  assign dac_if.duty_q      = duty_q;
  assign dac_if.frame_start = frame_q;

endmodule

// File: tb/tb_pwm_dac.sv
// Scoreboard bench for pwm_dac: stimulus queues per-frame expectations,
// a negedge monitor measures each frame's strobe time, duty and pulse shape.
module tb_pwm_dac;

  localparam int unsigned WIDTH = 8;
  localparam int FRAME = 1 << WIDTH;

  typedef struct {
    int     duty;
    int     high;
    longint fs_cyc;
  } exp_t;

  logic   clk;
  logic   rst_n;
  longint cyc;
  int     n_cmp;
  int     n_err;
  exp_t   exp_q[$];

  bit     in_frame;
  int     idx;
  int     hcnt;
  bit     shape_ok;
  exp_t   cur;

  pwm_dac_if #(.WIDTH(WIDTH)) bus ();

  pwm_dac #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .dac_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Expected duty is the attenuated sample; high time is clipped by an early abort.
  task automatic push_exp(input int s, input int a, input int cut);
    exp_t e;
    e.duty   = s / (1 << a);
    e.high   = (cut < e.duty) ? cut : e.duty;
    e.fs_cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pwm"},   longint'(bus.pwm_out), 0);
    check({tag, "_duty"},  longint'(bus.duty_q), 0);
    check({tag, "_frame"}, longint'(bus.frame_start), 0);
  endtask

  // One frame starting at the latch edge; en drops before edge cut+1, sample changes before edge chg.
  task automatic run_frame(input int s, input int a, input int cut, input int chg, input int chg_val);
    bus.sample_in = 8'(s);
    bus.amp_sel   = 2'(a);
    bus.en        = 1'b1;
    push_exp(s, a, cut);
    @(posedge clk); #1;
    for (int j = 1; j < FRAME; j++) begin
      if (j == chg) begin
        bus.sample_in = 8'(chg_val);
        bus.amp_sel   = 2'($urandom_range(0, 3));
      end
      if (j == cut + 1) bus.en = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_mid(input int s, input int a, input int k);
    bus.sample_in = 8'(s);
    bus.amp_sel   = 2'(a);
    bus.en        = 1'b1;
    push_exp(s, a, k);
    @(posedge clk); #1;
    repeat (k) @(posedge clk);
    @(negedge clk); #1;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    #1 check_idle("rst_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check_idle("post_rst_idle");
    end
  endtask

  task automatic close_frame();
    check("high_count", hcnt, cur.high);
    check("contiguous", longint'(shape_ok), 1);
    in_frame = 1'b0;
  endtask

  // Monitor: a frame opens on frame_start and closes after 2^WIDTH-1 further cycles.
  initial begin
    in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.frame_start) begin
        if (in_frame) close_frame();
        if (exp_q.size() == 0) begin
          check("spurious_frame_start", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("frame_start_cycle", cyc, cur.fs_cyc);
          check("duty_q", longint'(bus.duty_q), cur.duty);
          in_frame = 1'b1;
          idx      = 0;
          hcnt     = 0;
          shape_ok = 1'b1;
        end
      end else if (in_frame) begin
        idx++;
        if (bus.pwm_out) begin
          hcnt++;
          if (hcnt != idx) shape_ok = 1'b0;
        end
        if (idx == FRAME - 1) close_frame();
      end
    end
  end

  initial begin
    real r;
    int  s;
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.sample_in = '0;
    bus.amp_sel   = '0;

    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    rst_n = 1'b1;
    bus.sample_in = 8'd77;
    repeat (4) begin
      @(posedge clk); #1;
      check_idle("en_off_idle");
    end

    run_frame(100, 0, FRAME, 0, 0);
    run_frame(100, 0, FRAME, 0, 0);
    for (int a = 0; a < 4; a++) run_frame(200, a, FRAME, 0, 0);
    repeat (3) run_frame(0, 0, FRAME, 0, 0);
    repeat (2) run_frame(255, 0, FRAME, 0, 0);
    run_frame(40, 0, FRAME, 11, 220);
    run_frame(220, 0, FRAME, 0, 0);
    run_frame(180, 0, 60, 0, 0);
    run_frame(90, 1, FRAME, 0, 0);
    reset_mid(150, 0, 70);
    repeat (20) @(posedge clk);
    #1;

    // Full-wave rectified sine from the upstream generator, one sample per frame.
    for (int k = 0; k < 64; k++) begin
      r = 255.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 64.0);
      if (r < 0.0) r = -r;
      s = $rtoi(r + 0.5);
      run_frame(s, 0, FRAME, 0, 0);
    end

    for (int k = 0; k < 12; k++) begin
      run_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 0) ? FRAME : int'($urandom_range(0, 255)),
                int'($urandom_range(1, 255)), int'($urandom_range(0, 255)));
    end

    bus.en = 1'b0;
    for (int i = 0; i < 600 && (exp_q.size() != 0 || in_frame); i++) @(posedge clk);
    check("drain_pending", longint'(exp_q.size()) + longint'(in_frame), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
